// File: rtl/output_port_arbiter.sv
// Round-robin, burst-limited arbiter that pops FWFT port FIFOs into a single
// registered valid/ready output stage toward the network injection port.
module output_port_arbiter #(
   parameter int PACKET_BITS   = 97,
   parameter int NUM_OUT_PORTS = 7,
   parameter int BURST_LEN     = 4,
   localparam int SEL_BITS     = $clog2(NUM_OUT_PORTS)
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic [PACKET_BITS*NUM_OUT_PORTS-1:0] internal_out,
   input  logic [NUM_OUT_PORTS-1:0]           empty,
   output logic [NUM_OUT_PORTS-1:0]           rd_en_sel,
   input  logic [NUM_OUT_PORTS-1:0]           port_enable,
   input  logic                               ap_start,
   output logic [PACKET_BITS-1:0]             out_packet,
   output logic                               out_valid,
   input  logic                               out_ready,
   output logic [SEL_BITS-1:0]                out_src
);

   localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

   logic [NUM_OUT_PORTS-1:0] eligible;
   logic                     slot_free;
   logic                     load;
   logic                     burst_cont;
   logic                     scan_found;
   logic [SEL_BITS:0]        scan_sum;
   logic [SEL_BITS-1:0]      scan_idx;
   logic [SEL_BITS-1:0]      sel;
   logic [PACKET_BITS-1:0]   sel_packet;

   logic [SEL_BITS-1:0]      last_grant_q, last_grant_d;
   logic [CNT_W-1:0]         burst_cnt_q, burst_cnt_d;
   logic                     burst_active_q, burst_active_d;
   logic                     out_valid_q, out_valid_d;
   logic [PACKET_BITS-1:0]   out_packet_q, out_packet_d;
   logic [SEL_BITS-1:0]      out_src_q, out_src_d;

   always_comb begin
      eligible   = ~empty & port_enable & {NUM_OUT_PORTS{ap_start}};
      slot_free  = ~out_valid_q | out_ready;
      // Pops are held off while reset is asserted so no FIFO entry is lost.
      load       = reset & slot_free & (|eligible);
      burst_cont = burst_active_q & eligible[last_grant_q] &
                   (burst_cnt_q < CNT_W'(BURST_LEN - 1));

      // Rotation scan starts just after last_grant and visits last_grant last.
      sel        = last_grant_q;
      scan_found = 1'b0;
      scan_sum   = '0;
      scan_idx   = '0;
      for (int k = 1; k <= NUM_OUT_PORTS; k++) begin
         scan_sum = {1'b0, last_grant_q} + (SEL_BITS+1)'(k);
         if (scan_sum >= (SEL_BITS+1)'(NUM_OUT_PORTS))
            scan_sum = scan_sum - (SEL_BITS+1)'(NUM_OUT_PORTS);
         scan_idx = scan_sum[SEL_BITS-1:0];
         if (!scan_found && eligible[scan_idx]) begin
            sel        = scan_idx;
            scan_found = 1'b1;
         end
      end
      if (burst_cont)
         sel = last_grant_q;

      sel_packet = '0;
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
         if (sel == SEL_BITS'(i))
            sel_packet = internal_out[i*PACKET_BITS +: PACKET_BITS];
      end

      rd_en_sel = '0;
      if (load)
         rd_en_sel[sel] = 1'b1;
   end

   always_comb begin
      last_grant_d   = last_grant_q;
      burst_cnt_d    = burst_cnt_q;
      burst_active_d = burst_active_q;
      out_valid_d    = out_valid_q;
      out_packet_d   = out_packet_q;
      out_src_d      = out_src_q;
      if (load) begin
         out_packet_d   = sel_packet;
         out_src_d      = sel;
         out_valid_d    = 1'b1;
         last_grant_d   = sel;
         burst_cnt_d    = burst_cont ? burst_cnt_q + CNT_W'(1) : '0;
         burst_active_d = 1'b1;
      end else if (out_ready) begin
         out_valid_d    = 1'b0;
         burst_active_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         last_grant_q   <= SEL_BITS'(NUM_OUT_PORTS - 1);
         burst_cnt_q    <= '0;
         burst_active_q <= 1'b0;
         out_valid_q    <= 1'b0;
         out_packet_q   <= '0;
         out_src_q      <= '0;
      end else begin
         last_grant_q   <= last_grant_d;
         burst_cnt_q    <= burst_cnt_d;
         burst_active_q <= burst_active_d;
         out_valid_q    <= out_valid_d;
         out_packet_q   <= out_packet_d;
         out_src_q      <= out_src_d;
      end
   end

   assign out_packet = out_packet_q;
   assign out_valid  = out_valid_q;
   assign out_src    = out_src_q;

endmodule

// File: tb/tb_output_port_arbiter.sv
// Bench for output_port_arbiter: two instances (BURST_LEN 4 and 1) fed from
// queue-modelled FIFOs, checked every cycle against a rule-level reference model.
module tb_output_port_arbiter;

   localparam int PB = 97;
   localparam int NP = 7;
   localparam int SB = 3;
   typedef logic [PB-1:0] pkt_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset;
   logic          ap_start;
   logic          out_ready;
   logic [NP-1:0] port_enable;
   logic [NP-1:0]    empty_s [2];
   logic [PB*NP-1:0] io_s    [2];

   logic [NP-1:0] rd4, rd1;
   logic [PB-1:0] pkt4, pkt1;
   logic          vld4, vld1;
   logic [SB-1:0] src4, src1;

   logic [NP-1:0] rd_s  [2];
   logic [PB-1:0] pkt_s [2];
   logic          vld_s [2];
   logic [SB-1:0] src_s [2];

   output_port_arbiter #(.PACKET_BITS(PB), .NUM_OUT_PORTS(NP), .BURST_LEN(4)) u_dut4 (
      .clk(clk), .reset(reset), .internal_out(io_s[0]), .empty(empty_s[0]),
      .rd_en_sel(rd4), .port_enable(port_enable), .ap_start(ap_start),
      .out_packet(pkt4), .out_valid(vld4), .out_ready(out_ready), .out_src(src4));

   output_port_arbiter #(.PACKET_BITS(PB), .NUM_OUT_PORTS(NP), .BURST_LEN(1)) u_dut1 (
      .clk(clk), .reset(reset), .internal_out(io_s[1]), .empty(empty_s[1]),
      .rd_en_sel(rd1), .port_enable(port_enable), .ap_start(ap_start),
      .out_packet(pkt1), .out_valid(vld1), .out_ready(out_ready), .out_src(src1));

   always_comb begin
      rd_s[0] = rd4;   rd_s[1] = rd1;
      pkt_s[0] = pkt4; pkt_s[1] = pkt1;
      vld_s[0] = vld4; vld_s[1] = vld1;
      src_s[0] = src4; src_s[1] = src1;
   end

   // FIFO contents, reference model state and logging
   pkt_t fifo [2][NP][$];
   int   bl [2] = '{4, 1};
   int   m_lg [2], m_cnt [2], m_src [2];
   bit   m_act [2], m_v [2];
   pkt_t m_pkt [2];
   bit   p_ok [2], p_load [2], p_cont [2];
   int   p_sel [2];
   int   logq [2][$];
   pkt_t logpk [2][$];
   pkt_t pushed [$];
   bit   log_en = 1'b0;
   bit   chk_en = 1'b0;
   bit   rst_edge;
   int   seq = 0;
   int   n_chk = 0;
   int   n_fail = 0;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic refresh();
      for (int d = 0; d < 2; d++)
         for (int i = 0; i < NP; i++) begin
            empty_s[d][i] = (fifo[d][i].size() == 0);
            io_s[d][i*PB +: PB] = (fifo[d][i].size() != 0) ? fifo[d][i][0] : '0;
         end
   endtask

   task automatic push(input int p, input int n);
      pkt_t pk;
      for (int j = 0; j < n; j++) begin
         pk = {1'b0, 32'(seq), $urandom(), $urandom()};
         seq++;
         fifo[0][p].push_back(pk);
         fifo[1][p].push_back(pk);
         pushed.push_back(pk);
      end
      refresh();
   endtask

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         m_lg[d] = NP - 1; m_cnt[d] = 0; m_act[d] = 1'b0;
         m_v[d] = 1'b0; m_src[d] = 0; m_pkt[d] = '0; p_ok[d] = 1'b0;
      end
   endtask

   // Per-cycle expectation straight from the arbitration rules
   always @(negedge clk) begin
      if (chk_en) begin
         for (int d = 0; d < 2; d++) begin
            bit el [NP];
            bit any, load, cont, found;
            int sel, idx;
            logic [NP-1:0] exp_rd;
            string nm;
            nm = (d == 0) ? "bl4" : "bl1";
            if (!reset) begin
               chk({nm, " rd_en_sel in reset"}, 128'(rd_s[d]), 128'(0));
               chk({nm, " out_valid in reset"}, 128'(vld_s[d]), 128'(0));
               p_ok[d] = 1'b0;
            end else begin
               any = 1'b0;
               for (int i = 0; i < NP; i++) begin
                  el[i] = (fifo[d][i].size() > 0) && port_enable[i] && ap_start;
                  any = any | el[i];
               end
               load = (!m_v[d] || out_ready) && any;
               cont = m_act[d] && el[m_lg[d]] && (m_cnt[d] < bl[d] - 1);
               sel = m_lg[d];
               found = 1'b0;
               if (!cont)
                  for (int k = 1; k <= NP; k++) begin
                     idx = (m_lg[d] + k) % NP;
                     if (!found && el[idx]) begin sel = idx; found = 1'b1; end
                  end
               exp_rd = load ? NP'(1) << sel : '0;
               chk({nm, " rd_en_sel"}, 128'(rd_s[d]), 128'(exp_rd));
               chk({nm, " out_valid"}, 128'(vld_s[d]), 128'(m_v[d]));
               if (m_v[d]) begin
                  chk({nm, " out_packet"}, 128'(pkt_s[d]), 128'(m_pkt[d]));
                  chk({nm, " out_src"}, 128'(src_s[d]), 128'(m_src[d]));
               end
               p_ok[d] = 1'b1; p_load[d] = load; p_sel[d] = sel; p_cont[d] = cont;
            end
            if (log_en) begin
               logq[d].push_back(vld_s[d] ? int'(src_s[d]) : -1);
               logpk[d].push_back(pkt_s[d]);
            end
         end
      end
   end

   task automatic commit();
      for (int d = 0; d < 2; d++) begin
         if (p_ok[d] && rst_edge) begin
            if (p_load[d]) begin
               m_pkt[d] = fifo[d][p_sel[d]].pop_front();
               m_v[d]   = 1'b1;
               m_src[d] = p_sel[d];
               m_cnt[d] = p_cont[d] ? m_cnt[d] + 1 : 0;
               m_lg[d]  = p_sel[d];
               m_act[d] = 1'b1;
            end else if (out_ready) begin
               m_v[d]   = 1'b0;
               m_act[d] = 1'b0;
            end
         end
         p_ok[d] = 1'b0;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      rst_edge = reset;
      #1;
      commit();
      refresh();
   endtask

   task automatic ticks(input int n);
      for (int j = 0; j < n; j++) tick();
   endtask

   task automatic reset_all();
      reset = 1'b0;
      #1;
      model_reset();
      for (int d = 0; d < 2; d++)
         for (int i = 0; i < NP; i++) fifo[d][i].delete();
      refresh();
      ticks(2);
      reset = 1'b1;
   endtask

   task automatic start_log();
      for (int d = 0; d < 2; d++) begin logq[d].delete(); logpk[d].delete(); end
      log_en = 1'b1;
   endtask

   task automatic check_seq(input int d, input int exp_q[$], input string nm, input bit chk_pk);
      int f;
      f = -1;
      for (int j = logq[d].size() - 1; j >= 0; j--)
         if (logq[d][j] != -1) f = j;
      if (f < 0) begin
         chk({nm, " first valid"}, 128'(0), 128'(1));
         return;
      end
      for (int j = 0; j < exp_q.size(); j++) begin
         if (f + j < logq[d].size()) begin
            chk($sformatf("%s src[%0d]", nm, j), 128'(logq[d][f+j]), 128'(exp_q[j]));
            if (chk_pk)
               chk($sformatf("%s payload[%0d]", nm, j), 128'(logpk[d][f+j]), 128'(pushed[j]));
         end else
            chk($sformatf("%s src[%0d] present", nm, j), 128'(0), 128'(1));
      end
      if (f + exp_q.size() < logq[d].size())
         chk({nm, " idle after"}, 128'(logq[d][f+exp_q.size()]), 128'(-1));
   endtask

   initial begin
      int exp_q [$];
      logic [PB-1:0] hold_pkt [2];
      logic [SB-1:0] hold_src [2];

      reset = 1'b0; ap_start = 1'b1; out_ready = 1'b1; port_enable = '1;
      model_reset();
      refresh();
      for (int i = 0; i < NP; i++) push(i, 1);
      chk_en = 1'b1;
      ticks(3);
      chk("reset out_valid", 128'(vld4), 128'(0));
      chk("reset out_packet", 128'(pkt4), 128'(0));
      chk("reset rd_en_sel", 128'(rd4), 128'(0));
      reset = 1'b1;
      #1;
      chk("first pop bl4", 128'(rd4), 128'(7'b0000001));
      chk("first pop bl1", 128'(rd1), 128'(7'b0000001));
      ticks(10);

      // Three ports, three packets each
      reset_all();
      ap_start = 1'b0;
      push(0, 3); push(2, 3); push(5, 3);
      tick();
      start_log();
      ap_start = 1'b1;
      ticks(14);
      log_en = 1'b0;
      exp_q = '{0, 2, 5, 0, 2, 5, 0, 2, 5};
      check_seq(1, exp_q, "bl1 rotate", 1'b0);
      exp_q = '{0, 0, 0, 2, 2, 2, 5, 5, 5};
      check_seq(0, exp_q, "bl4 drain", 1'b0);

      // Two ports, eight packets each
      reset_all();
      ap_start = 1'b0;
      push(1, 8); push(4, 8);
      tick();
      start_log();
      ap_start = 1'b1;
      ticks(20);
      log_en = 1'b0;
      exp_q = '{1, 1, 1, 1, 4, 4, 4, 4, 1, 1, 1, 1, 4, 4, 4, 4};
      check_seq(0, exp_q, "bl4 burst", 1'b0);
      exp_q = '{1, 4, 1, 4, 1, 4, 1, 4, 1, 4, 1, 4, 1, 4, 1, 4};
      check_seq(1, exp_q, "bl1 alt", 1'b0);

      // Single enabled port, payload order
      reset_all();
      ap_start = 1'b0;
      port_enable = 7'b0001000;
      pushed.delete();
      push(3, 10);
      push(0, 2); push(6, 2);
      tick();
      start_log();
      ap_start = 1'b1;
      ticks(15);
      log_en = 1'b0;
      exp_q = '{3, 3, 3, 3, 3, 3, 3, 3, 3, 3};
      check_seq(0, exp_q, "bl4 single", 1'b1);
      check_seq(1, exp_q, "bl1 single", 1'b1);
      port_enable = '1;

      // Backpressure then ap_start drop
      reset_all();
      push(2, 5); push(5, 3);
      ticks(2);
      out_ready = 1'b0;
      for (int d = 0; d < 2; d++) begin hold_pkt[d] = pkt_s[d]; hold_src[d] = src_s[d]; end
      for (int j = 0; j < 3; j++) begin
         tick();
         #1;
         for (int d = 0; d < 2; d++) begin
            chk("bp rd_en_sel", 128'(rd_s[d]), 128'(0));
            chk("bp out_packet", 128'(pkt_s[d]), 128'(hold_pkt[d]));
            chk("bp out_src", 128'(src_s[d]), 128'(hold_src[d]));
         end
      end
      out_ready = 1'b1;
      #1;
      chk("bp release bl4", 128'(rd4), 128'(7'b0000100));
      chk("bp release bl1", 128'(rd1), 128'(7'b0000100));
      tick();
      ap_start = 1'b0;
      #1;
      chk("ap_start low held", 128'(vld4), 128'(1));
      chk("ap_start low rd", 128'(rd4), 128'(0));
      tick();
      chk("ap_start drained", 128'(vld4), 128'(0));
      ticks(3);
      chk("ap_start idle rd", 128'(rd4), 128'(0));

      // Asynchronous reset with a held packet
      ap_start = 1'b1;
      out_ready = 1'b0;
      push(0, 3);
      ticks(2);
      #1;
      chk("pre-reset held", 128'(vld4), 128'(1));
      reset = 1'b0;
      #1;
      chk("async reset bl4", 128'(vld4), 128'(0));
      chk("async reset bl1", 128'(vld1), 128'(0));
      model_reset();
      ticks(2);
      out_ready = 1'b1;
      reset = 1'b1;
      #1;
      chk("post-reset pop bl4", 128'(rd4), 128'(7'b0000001));
      chk("post-reset pop bl1", 128'(rd1), 128'(7'b0000001));

      // Randomised traffic
      for (int c = 0; c < 1500; c++) begin
         tick();
         out_ready = ($urandom_range(0, 3) != 0);
         ap_start  = ($urandom_range(0, 15) != 0);
         if ($urandom_range(0, 19) == 0) port_enable = NP'($urandom_range(1, 127));
         for (int i = 0; i < NP; i++)
            if ($urandom_range(0, 2) == 0 && fifo[0][i].size() < 6) push(i, 1);
         refresh();
      end
      tick();
      chk_en = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
